// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path: framing constants, CRC-32
// constants, receive FSM states and the decoded GMII stage-0 word.
package rgmii_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CAP_W     = 10;
  localparam int unsigned BUF_DEPTH = 5;

  localparam logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

  // One GMII receive beat rebuilt from the DDR capture word
  typedef struct packed {
    logic              er;
    logic              dv;
    logic [BYTE_W-1:0] data;
  } gmii_rx_t;

  // Rising edge carries RXD[3:0]/DV, falling edge carries RXD[7:4]/(DV^ER)
  function automatic gmii_rx_t decode_capture(input logic [CAP_W-1:0] q);
    gmii_rx_t r;
    r.data = {q[8:5], q[3:0]};
    r.dv   = q[4];
    r.er   = q[4] ^ q[9];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 (poly 0xEDB88320),
// data consumed LSB first. Shared by the RX FCS checker and TX FCS generator.
//   crc_in  : current CRC register
//   data    : byte to fold in
//   crc_out : CRC register after the byte
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0]       crc_in,
  input  logic [BYTE_W-1:0] data,
  output logic [31:0]       crc_out
);

  // Bit-serial LFSR unrolled over the eight data bits
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_frame.sv
// RGMII receive framer: rebuilds GMII beats from the DDR capture word, strips
// preamble/SFD, holds back the trailing FCS with a 5-byte delay line, checks
// CRC-32 and length, and emits a sof/eof/err framed byte stream.
//   clk, rst   : RX clock, synchronous active-high reset
//   rgmii_q    : 10-bit capture word from the IDDR stage
//   out_data   : payload byte, qualified by out_valid (no backpressure)
//   out_sof    : first payload byte of a frame
//   out_eof    : last payload byte of a frame
//   out_err    : frame bad (CRC, RX_ER, length); meaningful with out_eof
//   stat_good  : one pulse per frame ended cleanly
//   stat_bad   : one pulse per frame ended in error, including runts < 5 bytes
module rgmii_rx_frame
  import rgmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned LEN_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CAP_W-1:0]  rgmii_q,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_err,
  output logic              stat_good,
  output logic              stat_bad
);

  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BUF_DEPTH);
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;

  typedef logic [BUF_DEPTH-1:0][BYTE_W-1:0] dly_t;

  gmii_rx_t    s0_q, s0_d;
  rx_state_e   state_q, state_d;
  dly_t        dly_q, dly_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        err_q, err_d;

  logic [BYTE_W-1:0] out_data_d;
  logic out_valid_d, out_sof_d, out_eof_d, out_err_d;
  logic stat_good_d, stat_bad_d;

  logic live, full, ending, bad;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (s0_q.data),
    .crc_out (crc_next)
  );

  // Next state, datapath update and output look-ahead
  always_comb begin
    s0_d    = decode_capture(rgmii_q);
    state_d = state_q;
    dly_d   = dly_q;
    len_d   = len_q;
    crc_d   = crc_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, PRE: begin
        if (s0_q.dv) begin
          if (s0_q.data == PREAMBLE_BYTE) begin
            state_d = PRE;
          end else if (s0_q.data == SFD_BYTE) begin
            state_d = DATA;
            dly_d   = '0;
            len_d   = '0;
            crc_d   = CRC_INIT;
            err_d   = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (s0_q.dv) begin
          dly_d = {dly_q[BUF_DEPTH-2:0], s0_q.data};
          crc_d = crc_next;
          err_d = err_q | s0_q.er;
          if (len_q != LEN_SAT) begin
            len_d = len_q + LEN_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!s0_q.dv) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are evaluated on next-cycle state with the incoming DV so they
    // can be registered without adding latency: a beat leaves when the delay
    // line is full, and the first DV-low cycle in DATA closes the frame.
    live   = (state_d == DATA);
    full   = (len_d >= LEN_FULL);
    ending = live & ~s0_d.dv;
    bad    = (crc_d != CRC_RESIDUE) | err_d | (len_d < LEN_MIN) | (len_d > LEN_MAX);

    out_valid_d = live & full;
    out_data_d  = out_valid_d ? dly_d[BUF_DEPTH-1] : '0;
    out_sof_d   = live & (len_d == LEN_FULL);
    out_eof_d   = ending & full;
    out_err_d   = ending & full & bad;
    stat_good_d = ending & full & ~bad;
    stat_bad_d  = ending & (~full | bad);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q      <= '0;
      state_q   <= IDLE;
      dly_q     <= '0;
      len_q     <= '0;
      crc_q     <= CRC_INIT;
      err_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;
    end else begin
      s0_q      <= s0_d;
      state_q   <= state_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_sof   <= out_sof_d;
      out_eof   <= out_eof_d;
      out_err   <= out_err_d;
      stat_good <= stat_good_d;
      stat_bad  <= stat_bad_d;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Directed bench for rgmii_rx_frame: frames are built with a bench-side FCS,
// driven through the capture-word encoding, and the output stream is
// collected by a monitor and compared against the payload that was sent.
module tb_rgmii_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rgmii_q;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eof, out_err, stat_good, stat_bad;

  always #5 clk = ~clk;

  rgmii_rx_frame dut (
    .clk       (clk),
    .rst       (rst),
    .rgmii_q   (rgmii_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_err   (out_err),
    .stat_good (stat_good),
    .stat_bad  (stat_bad)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state (written only by the monitor)
  logic [7:0] got_q[$];
  int n_sof = 0, n_eof = 0, n_eoferr = 0, n_se = 0, n_good = 0, n_bad = 0;
  int last_sof_cyc = 0;

  // Test-side state
  logic [7:0] body[$];
  logic [7:0] exp_q[$];
  int b_got, b_sof, b_eof, b_eoferr, b_se, b_good, b_bad;
  int first_in_cyc;

  always @(negedge clk) begin
    if (out_valid) begin
      got_q.push_back(out_data);
      if (out_sof) begin
        n_sof <= n_sof + 1;
        last_sof_cyc <= cyc;
      end
      if (out_eof) begin
        n_eof <= n_eof + 1;
        if (out_err) n_eoferr <= n_eoferr + 1;
      end
      if (out_sof && out_eof) n_se <= n_se + 1;
    end
    if (stat_good) n_good <= n_good + 1;
    if (stat_bad)  n_bad  <= n_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] enc(input logic [7:0] b, input logic dv, input logic er);
    return {dv ^ er, b[7:4], dv, b[3:0]};
  endfunction

  task automatic put(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk);
    rgmii_q = enc(b, dv, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Replace body with n incrementing bytes; optionally expect them at the output
  task automatic make_payload(input int n, input logic [7:0] start, input bit expect_out);
    body.delete();
    for (int i = 0; i < n; i++) begin
      body.push_back(8'(start + 8'(i)));
      if (expect_out) exp_q.push_back(8'(start + 8'(i)));
    end
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < body.size(); i++) c = crc_byte(c, body[i]);
    c = ~c;
    body.push_back(c[7:0]);
    body.push_back(c[15:8]);
    body.push_back(c[23:16]);
    body.push_back(c[31:24]);
  endtask

  // npre preamble bytes, a terminating byte, the body, then one DV-low cycle
  task automatic send(input int npre, input logic [7:0] last_pre, input int er_idx);
    for (int i = 0; i < npre; i++) put(8'h55, 1'b1, 1'b0);
    put(last_pre, 1'b1, 1'b0);
    for (int i = 0; i < body.size(); i++) begin
      put(body[i], 1'b1, (i == er_idx));
      if (i == 0) first_in_cyc = cyc;
    end
    put(8'h00, 1'b0, 1'b0);
  endtask

  task automatic mark();
    exp_q.delete();
    b_got = got_q.size();
    b_sof = n_sof; b_eof = n_eof; b_eoferr = n_eoferr;
    b_se = n_se; b_good = n_good; b_bad = n_bad;
  endtask

  task automatic check_frame(input string tag, input int beats, input int sofs, input int eofs,
                             input int errs, input int goods, input int bads);
    int mism;
    int ng;
    mism = 0;
    ng = got_q.size() - b_got;
    for (int i = 0; i < ng; i++) begin
      if (i >= exp_q.size() || got_q[b_got + i] !== exp_q[i]) mism++;
    end
    chk({tag, ".beats"}, 32'(ng), 32'(beats));
    chk({tag, ".data"},  32'(mism), 32'd0);
    chk({tag, ".sof"},   32'(n_sof - b_sof), 32'(sofs));
    chk({tag, ".eof"},   32'(n_eof - b_eof), 32'(eofs));
    chk({tag, ".err"},   32'(n_eoferr - b_eoferr), 32'(errs));
    chk({tag, ".good"},  32'(n_good - b_good), 32'(goods));
    chk({tag, ".bad"},   32'(n_bad - b_bad), 32'(bads));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({out_data, out_valid, out_sof, out_eof, out_err, stat_good, stat_bad});
  endfunction

  initial begin
    rst = 1'b1;
    rgmii_q = '0;
    repeat (3) @(negedge clk);
    chk("reset.outs", all_outs(), 32'd0);
    rst = 1'b0;
    idle(3);

    // Good 64-byte frame, latency of first beat
    mark();
    make_payload(60, 8'h00, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("good64", 60, 1, 1, 0, 1, 0);
    chk("good64.lat", 32'(last_sof_cyc - first_in_cyc), 32'd6);

    // Same frame with one FCS bit flipped
    mark();
    make_payload(60, 8'h00, 1'b1); add_fcs();
    body[60] = body[60] ^ 8'h01;
    send(7, 8'hD5, -1); idle(10);
    check_frame("badfcs", 60, 1, 1, 1, 0, 1);

    // RX_ER on payload byte 10
    mark();
    make_payload(60, 8'h00, 1'b1); add_fcs();
    send(7, 8'hD5, 10); idle(10);
    check_frame("rxer", 60, 1, 1, 1, 0, 1);

    // Runt with valid FCS (24 bytes)
    mark();
    make_payload(20, 8'hA0, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("runt", 20, 1, 1, 1, 0, 1);

    // One byte under the minimum (63 bytes), short preamble
    mark();
    make_payload(59, 8'h11, 1'b1); add_fcs();
    send(1, 8'hD5, -1); idle(10);
    check_frame("len63", 59, 1, 1, 1, 0, 1);

    // Exactly 5 bytes: sof and eof on the same beat
    mark();
    make_payload(1, 8'h5A, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("len5", 1, 1, 1, 1, 0, 1);
    chk("len5.sofeof", 32'(n_se - b_se), 32'd1);

    // 3 bytes after SFD: nothing emitted, bad pulse
    mark();
    make_payload(3, 8'h01, 1'b0);
    send(7, 8'hD5, -1); idle(10);
    check_frame("len3", 0, 0, 0, 0, 0, 1);

    // Broken preamble 0x55,0x57: dropped silently
    mark();
    make_payload(20, 8'hD5, 1'b0); add_fcs();
    send(1, 8'h57, -1); idle(10);
    check_frame("drop", 0, 0, 0, 0, 0, 0);

    // Two good frames with a single DV-low cycle between them
    mark();
    make_payload(60, 8'h40, 1'b1); add_fcs();
    send(7, 8'hD5, -1);
    make_payload(60, 8'hC0, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("b2b", 120, 2, 2, 0, 2, 0);

    // Maximum length (1522) is accepted, one more is flagged
    mark();
    make_payload(1518, 8'h00, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("len1522", 1518, 1, 1, 0, 1, 0);
    mark();
    make_payload(1519, 8'h00, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("len1523", 1519, 1, 1, 1, 0, 1);

    // Reset in the middle of a payload, then a clean frame
    mark();
    make_payload(30, 8'h10, 1'b0);
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) put(body[i], 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rgmii_q = enc(8'h77, 1'b1, 1'b0);
    @(negedge clk);
    chk("midrst.outs1", all_outs(), 32'd0);
    @(negedge clk);
    chk("midrst.outs2", all_outs(), 32'd0);
    rst = 1'b0;
    rgmii_q = enc(8'h00, 1'b0, 1'b0);
    idle(10);
    chk("midrst.eof",  32'(n_eof - b_eof), 32'd0);
    chk("midrst.stat", 32'((n_good - b_good) + (n_bad - b_bad)), 32'd0);
    mark();
    make_payload(60, 8'h80, 1'b1); add_fcs();
    send(7, 8'hD5, -1); idle(10);
    check_frame("afterrst", 60, 1, 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
